// File: rtl/scene_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : scene_pkg                                                       |
// | Purpose  : Shared scene codes, default widths and the fade FSM state type  |
// |            for the scene fade compositor and its helpers.                  |
// | Ports    : none (package)                                                  |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
package scene_pkg;

  localparam int DEF_SCENE_W = 4;
  localparam int DEF_ADDR_W  = 17;
  localparam int DEF_RGB_W   = 12;

  localparam logic [DEF_SCENE_W-1:0] SCENE_START  = 4'd1;
  localparam logic [DEF_SCENE_W-1:0] SCENE_CHOOSE = 4'd2;
  localparam logic [DEF_SCENE_W-1:0] SCENE_FIGHT  = 4'd3;
  localparam logic [DEF_SCENE_W-1:0] SCENE_WIN    = 4'd4;

  typedef enum logic [1:0] {
    SHOW     = 2'd0,
    FADE_OUT = 2'd1,
    FADE_IN  = 2'd2
  } fade_state_e;

endpackage
`default_nettype wire

// File: rtl/rgb_scaler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : rgb_scaler                                                      |
// | Purpose  : Combinational brightness scaler. Each of the three colour       |
// |            components c becomes (c * level) >> FADE_SHIFT.                 |
// | Ports    : rgb_i   - colour in, components ordered R,G,B (MSB first)       |
// |            level_i - brightness 0..2^FADE_SHIFT                            |
// |            rgb_o   - scaled colour                                         |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module rgb_scaler #(
  parameter int RGB_W      = 12,
  parameter int FADE_SHIFT = 2
) (
  input  logic [RGB_W-1:0]    rgb_i,
  input  logic [FADE_SHIFT:0] level_i,
  output logic [RGB_W-1:0]    rgb_o
);

  localparam int CW = RGB_W / 3;

  // The product never exceeds (2^CW-1)*2^FADE_SHIFT, so CW+FADE_SHIFT bits
  // hold it exactly; the shift-and-truncate keeps the top CW bits.
  for (genvar g = 0; g < 3; g++) begin : g_comp
    assign rgb_o[g*CW +: CW] =
      CW'(({{FADE_SHIFT{1'b0}}, rgb_i[g*CW +: CW]} *
           {{(CW-1){1'b0}}, level_i}) >> FADE_SHIFT);
  end

endmodule
`default_nettype wire

// File: rtl/scene_fade_compositor.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : scene_fade_compositor                                           |
// | Purpose  : Selects the displayed scene among NUM_SCENES renderer channels, |
// |            drives the shared image-memory address and the VGA colour, and  |
// |            switches scenes on frame boundaries.                            |
// |            SCENE_FADE_EN defined : brightness fade-out / fade-in between   |
// |                                    scenes.                                 |
// |            SCENE_FADE_EN undefined: tear-free switch at the next frame     |
// |                                    tick, full brightness, no multiplier.   |
// | Ports    : clk, rst        - clock, synchronous active-high reset          |
// |            valid, vsync    - VGA active-video flag, active-low vsync       |
// |            scene_state     - requested scene code                          |
// |            scene_rgb/addr  - packed per-channel colours / pixel addresses  |
// |            pixel_addr_out  - address of the shown scene (combinational)    |
// |            rgb_out         - registered composited colour                  |
// |            shown_scene     - currently displayed scene code                |
// |            busy            - a scene transition is in progress             |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module scene_fade_compositor
  import scene_pkg::*;
#(
  parameter int NUM_SCENES = 4,
  parameter int SCENE_W    = DEF_SCENE_W,
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int RGB_W      = DEF_RGB_W,
  parameter int FADE_SHIFT = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         valid,
  input  logic                         vsync,
  input  logic [SCENE_W-1:0]           scene_state,
  input  logic [NUM_SCENES*RGB_W-1:0]  scene_rgb,
  input  logic [NUM_SCENES*ADDR_W-1:0] scene_addr,
  output logic [ADDR_W-1:0]            pixel_addr_out,
  output logic [RGB_W-1:0]             rgb_out,
  output logic [SCENE_W-1:0]           shown_scene,
  output logic                         busy
);

  function automatic logic f_valid(input logic [SCENE_W-1:0] code);
    return (code != '0) && (int'(code) <= NUM_SCENES);
  endfunction

  fade_state_e          state_q, state_d;
  logic [SCENE_W-1:0]   shown_q, shown_d;
  logic [RGB_W-1:0]     rgb_q, rgb_d;
  logic                 busy_q;
  logic                 vsync_q;
  logic [RGB_W-1:0]     sel_rgb;
  logic                 tick, same, snap;

`ifdef SCENE_FADE_EN
  localparam int                FULL_I = 1 << FADE_SHIFT;
  localparam logic [FADE_SHIFT:0] FULL    = (FADE_SHIFT+1)'(FULL_I);
  localparam logic [FADE_SHIFT:0] FULL_M1 = (FADE_SHIFT+1)'(FULL_I - 1);
  localparam logic [FADE_SHIFT:0] ONE     = (FADE_SHIFT+1)'(1);

  logic [FADE_SHIFT:0] level_q, level_d;
  logic [RGB_W-1:0]    scaled_rgb;

  rgb_scaler #(
    .RGB_W      (RGB_W),
    .FADE_SHIFT (FADE_SHIFT)
  ) u_scaler (
    .rgb_i   (sel_rgb),
    .level_i (level_q),
    .rgb_o   (scaled_rgb)
  );
`endif

  // Channel select; an out-of-range code yields address 0 and black.
  always_comb begin
    sel_rgb        = '0;
    pixel_addr_out = '0;
    for (int i = 0; i < NUM_SCENES; i++) begin
      if (shown_q == SCENE_W'(i + 1)) begin
        sel_rgb        = scene_rgb[i*RGB_W +: RGB_W];
        pixel_addr_out = scene_addr[i*ADDR_W +: ADDR_W];
      end
    end
  end

  assign tick = vsync_q & ~vsync;  // falling edge of active-low vsync
  assign same = (scene_state == shown_q);
  assign snap = !f_valid(shown_q) && f_valid(scene_state) && !same;

  always_comb begin
    state_d = state_q;
    shown_d = shown_q;
`ifdef SCENE_FADE_EN
    level_d = level_q;
`endif
    if (snap) begin
      // Nothing sensible is on screen, so jump straight to the new scene.
      shown_d = scene_state;
      state_d = SHOW;
`ifdef SCENE_FADE_EN
      level_d = FULL;
`endif
    end else begin
      case (state_q)
        SHOW: begin
          if (!same) state_d = FADE_OUT;
        end
        FADE_OUT: begin
`ifdef SCENE_FADE_EN
          if (same) begin
            state_d = FADE_IN;
          end else if (tick) begin
            // Saturating at 0 covers re-entry from an interrupted fade-in.
            if (level_q <= ONE) begin
              level_d = '0;
              shown_d = scene_state;
              state_d = FADE_IN;
            end else begin
              level_d = level_q - ONE;
            end
          end
`else
          // Pending switch: cancel if the request returns, else latch at tick.
          if (same) begin
            state_d = SHOW;
          end else if (tick) begin
            shown_d = scene_state;
            state_d = SHOW;
          end
`endif
        end
        FADE_IN: begin
`ifdef SCENE_FADE_EN
          if (!same) begin
            state_d = FADE_OUT;
          end else if (tick) begin
            if (level_q >= FULL_M1) begin
              level_d = FULL;
              state_d = SHOW;
            end else begin
              level_d = level_q + ONE;
            end
          end
`else
          state_d = SHOW;
`endif
        end
        default: state_d = SHOW;
      endcase
    end
  end

`ifdef SCENE_FADE_EN
  assign rgb_d = valid ? scaled_rgb : '0;
`else
  assign rgb_d = valid ? sel_rgb : '0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= SHOW;
      shown_q <= '0;
      rgb_q   <= '0;
      busy_q  <= 1'b0;
      vsync_q <= 1'b1;
`ifdef SCENE_FADE_EN
      level_q <= FULL;
`endif
    end else begin
      state_q <= state_d;
      shown_q <= shown_d;
      rgb_q   <= rgb_d;
      busy_q  <= (state_d != SHOW);
      vsync_q <= vsync;
`ifdef SCENE_FADE_EN
      level_q <= level_d;
`endif
    end
  end

  assign rgb_out     = rgb_q;
  assign shown_scene = shown_q;
  assign busy        = busy_q;

endmodule
`default_nettype wire
